// File: rtl/cv32e40p_sleep_sequencer.sv
// Sleep entry/exit sequencer for the core clock gate: drain, power-manager
// handshake, gated sleep, and a programmable settling delay on wake.
module cv32e40p_sleep_sequencer #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk_ungated_i,
   input  logic             rst_n,
   input  logic             fetch_enable_i,
   input  logic             wfi_req_i,
   input  logic             debug_no_sleep_i,
   input  logic             wake_event_i,
   input  logic             if_busy_i,
   input  logic             lsu_busy_i,
   input  logic             apu_busy_i,
   input  logic             pm_sleep_ack_i,
   input  logic [3:0]       cfg_wake_delay_i,
   output logic             clock_en_o,
   output logic             core_sleep_o,
   output logic             pm_sleep_req_o,
   output logic             wake_done_o,
   output logic [CNT_W-1:0] sleep_cnt_o,
   output logic [2:0]       fsm_state_o
);

   typedef enum logic [2:0] {
      S_RESET = 3'd0,
      S_RUN   = 3'd1,
      S_DRAIN = 3'd2,
      S_REQ   = 3'd3,
      S_SLEEP = 3'd4,
      S_WAKE  = 3'd5
   } state_e;

   state_e           state_q, state_d;
   logic [3:0]       wake_cnt_q, wake_cnt_d;
   logic [CNT_W-1:0] sleep_cnt_q, sleep_cnt_d;
   logic             wake_done_q, wake_done_d;
   logic             busy;

   assign busy = if_busy_i | lsu_busy_i | apu_busy_i;

   always_ff @(posedge clk_ungated_i or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_RESET;
         wake_cnt_q  <= '0;
         sleep_cnt_q <= '0;
         wake_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         wake_cnt_q  <= wake_cnt_d;
         sleep_cnt_q <= sleep_cnt_d;
         wake_done_q <= wake_done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_RESET: if (fetch_enable_i) state_d = S_RUN;
         S_RUN:   if (wfi_req_i && !debug_no_sleep_i && !wake_event_i) state_d = S_DRAIN;
         S_DRAIN: begin
            if (wake_event_i || debug_no_sleep_i) state_d = S_RUN;
            else if (!busy)                       state_d = S_REQ;
         end
         S_REQ: begin
            // A pending wake beats a simultaneous ack: never gate the clock.
            if (wake_event_i)        state_d = S_WAKE;
            else if (pm_sleep_ack_i) state_d = S_SLEEP;
         end
         S_SLEEP: if (wake_event_i) state_d = S_WAKE;
         S_WAKE:  if (wake_cnt_q == 4'd0) state_d = S_RUN;
         default: state_d = S_RESET;
      endcase
   end

   always_comb begin
      wake_cnt_d  = wake_cnt_q;
      sleep_cnt_d = sleep_cnt_q;
      wake_done_d = (state_q == S_WAKE) && (state_d == S_RUN);
      if (state_d == S_WAKE && state_q != S_WAKE) begin
         wake_cnt_d = cfg_wake_delay_i;
      end else if (state_q == S_WAKE && wake_cnt_q != 4'd0) begin
         wake_cnt_d = wake_cnt_q - 4'd1;
      end
      if (state_q == S_REQ && state_d == S_SLEEP) begin
         sleep_cnt_d = '0;
      end else if (state_q == S_SLEEP && sleep_cnt_q != '1) begin
         sleep_cnt_d = sleep_cnt_q + CNT_W'(1);
      end
   end

   // Outputs decode the registered state only so the gate enable cannot glitch.
   always_comb begin
      clock_en_o     = 1'b0;
      core_sleep_o   = 1'b0;
      pm_sleep_req_o = 1'b0;
      case (state_q)
         S_RUN, S_DRAIN, S_WAKE: clock_en_o = 1'b1;
         S_REQ: begin
            clock_en_o     = 1'b1;
            pm_sleep_req_o = 1'b1;
         end
         S_SLEEP: begin
            core_sleep_o   = 1'b1;
            pm_sleep_req_o = 1'b1;
         end
         default: ;
      endcase
   end

   assign wake_done_o = wake_done_q;
   assign sleep_cnt_o = sleep_cnt_q;
   assign fsm_state_o = state_q;

endmodule
